// File: rtl/variable_node_unit.sv
// Serial LDPC variable node: accumulates a channel LLR plus DV check messages,
// then streams back DV extrinsic messages (total minus own input) and a hard decision.
module variable_node_unit #(
    parameter int DV    = 3,
    parameter int LLR_W = 6,
    parameter int C2V_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch_valid,
    input  logic [LLR_W-1:0] ch_llr,
    output logic             ch_ready,
    input  logic             c2v_valid,
    input  logic [C2V_W-1:0] c2v_msg,
    output logic             c2v_ready,
    output logic             v2c_valid,
    output logic [LLR_W-1:0] v2c_msg,
    input  logic             v2c_ready,
    output logic [3:0]       v2c_idx,
    output logic             hard_bit
);
    localparam int ACC_W = LLR_W + 4;
    localparam logic signed [ACC_W-1:0] P_MAX = ACC_W'(2**(LLR_W-1) - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_mem [DV];
    logic                     r_hard;

    logic                     w_ch_xfer;
    logic                     w_c2v_xfer;
    logic                     w_v2c_xfer;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_ch_mag;
    logic signed [ACC_W-1:0]  w_ch_tc;
    logic signed [ACC_W-1:0]  w_c2v_mag;
    logic signed [ACC_W-1:0]  w_c2v_tc;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_sel;
    logic signed [ACC_W-1:0]  w_diff;
    logic signed [ACC_W-1:0]  w_sat;
    logic                     w_neg;
    logic [LLR_W-2:0]         w_mag;

    // Negating a zero magnitude yields zero, so negative zero maps to 0 for free.
    assign w_ch_mag  = {{(ACC_W-LLR_W+1){1'b0}}, ch_llr[LLR_W-2:0]};
    assign w_ch_tc   = ch_llr[LLR_W-1] ? -w_ch_mag : w_ch_mag;
    assign w_c2v_mag = {{(ACC_W-C2V_W+1){1'b0}}, c2v_msg[C2V_W-2:0]};
    assign w_c2v_tc  = c2v_msg[C2V_W-1] ? -w_c2v_mag : w_c2v_mag;
    assign w_acc_sum = r_acc + w_c2v_tc;

    assign w_ch_xfer  = ch_valid & ch_ready;
    assign w_c2v_xfer = c2v_valid & c2v_ready;
    assign w_v2c_xfer = v2c_valid & v2c_ready;
    assign w_last     = (r_cnt == 4'(DV - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Handshake outputs are masked by rst so nothing looks ready while reset is held.
    always_comb begin
        w_next    = r_state;
        ch_ready  = 1'b0;
        c2v_ready = 1'b0;
        v2c_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                ch_ready = ~rst;
                if (w_ch_xfer) w_next = COLLECT;
            end
            COLLECT: begin
                c2v_ready = ~rst;
                if (w_c2v_xfer && w_last) w_next = EMIT;
            end
            EMIT: begin
                v2c_valid = ~rst;
                if (w_v2c_xfer && w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_hard <= 1'b0;
            for (int unsigned i = 0; i < DV; i++) r_mem[i] <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_ch_xfer) begin
                        r_acc <= w_ch_tc;
                        r_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (w_c2v_xfer) begin
                        for (int unsigned i = 0; i < DV; i++)
                            if (r_cnt == 4'(i)) r_mem[i] <= w_c2v_tc;
                        r_acc <= w_acc_sum;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_hard <= w_acc_sum[ACC_W-1];
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (w_v2c_xfer) r_cnt <= w_last ? '0 : r_cnt + 4'd1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < DV; i++)
            if (r_cnt == 4'(i)) w_sel = r_mem[i];
    end

    assign w_diff = r_acc - w_sel;

    always_comb begin
        w_sat = w_diff;
        if (w_diff > P_MAX)       w_sat = P_MAX;
        else if (w_diff < -P_MAX) w_sat = -P_MAX;
    end

    assign w_neg    = w_sat[ACC_W-1];
    assign w_mag    = (LLR_W-1)'(w_neg ? -w_sat : w_sat);
    assign v2c_msg  = v2c_valid ? {w_neg, w_mag} : '0;
    assign v2c_idx  = r_cnt;
    assign hard_bit = r_hard;
endmodule

// File: tb/tb_variable_node_unit.sv
// Directed bench for variable_node_unit: arithmetic model of the extrinsic
// messages plus a per-cycle compare process and hand-computed literals.
module tb_variable_node_unit;
    localparam int DV    = 3;
    localparam int LLR_W = 6;
    localparam int C2V_W = 5;
    localparam int MAXV  = 2**(LLR_W-1) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ch_valid = 1'b0;
    logic [LLR_W-1:0] ch_llr = '0;
    logic             ch_ready;
    logic             c2v_valid = 1'b0;
    logic [C2V_W-1:0] c2v_msg = '0;
    logic             c2v_ready;
    logic             v2c_valid;
    logic [LLR_W-1:0] v2c_msg;
    logic             v2c_ready = 1'b1;
    logic [3:0]       v2c_idx;
    logic             hard_bit;

    int errors = 0;
    int checks = 0;

    // model state
    logic [LLR_W-1:0] m_exp [DV];
    logic             m_hard = 1'b0;
    logic             m_hard_pend = 1'b0;
    logic             m_active = 1'b0;
    int               m_idx = 0;
    logic             cmp_en = 1'b0;

    variable_node_unit #(.DV(DV), .LLR_W(LLR_W), .C2V_W(C2V_W)) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_llr(ch_llr), .ch_ready(ch_ready),
        .c2v_valid(c2v_valid), .c2v_msg(c2v_msg), .c2v_ready(c2v_ready),
        .v2c_valid(v2c_valid), .v2c_msg(v2c_msg), .v2c_ready(v2c_ready),
        .v2c_idx(v2c_idx), .hard_bit(hard_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sm2int(input int v, input int w);
        int mag;
        mag = v & ((1 << (w-1)) - 1);
        return ((v >> (w-1)) & 1) ? -mag : mag;
    endfunction

    task automatic set_model(input logic [LLR_W-1:0] ch, input logic [C2V_W-1:0] c0,
                             input logic [C2V_W-1:0] c1, input logic [C2V_W-1:0] c2);
        int c [DV];
        int tot;
        int d;
        c[0] = sm2int(int'(c0), C2V_W);
        c[1] = sm2int(int'(c1), C2V_W);
        c[2] = sm2int(int'(c2), C2V_W);
        tot = sm2int(int'(ch), LLR_W) + c[0] + c[1] + c[2];
        for (int k = 0; k < DV; k++) begin
            d = tot - c[k];
            if (d > MAXV)  d = MAXV;
            if (d < -MAXV) d = -MAXV;
            m_exp[k] = (d < 0) ? LLR_W'((1 << (LLR_W-1)) | -d) : LLR_W'(d);
        end
        m_hard_pend = (tot < 0);
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("v2c_valid", 32'(v2c_valid), 32'(m_active));
            chk("hard_bit", 32'(hard_bit), 32'(m_hard));
            if (m_active && v2c_valid) begin
                chk("v2c_idx", 32'(v2c_idx), 32'(m_idx));
                chk("v2c_msg", 32'(v2c_msg), 32'(m_exp[m_idx]));
                if (v2c_ready) begin
                    m_idx++;
                    if (m_idx == DV) m_active = 1'b0;
                end
            end
            if (rst) begin
                m_active = 1'b0;
                m_hard   = 1'b0;
                m_idx    = 0;
            end
        end
    end

    task automatic send_ch(input logic [LLR_W-1:0] v);
        int waits = 0;
        ch_valid = 1'b1;
        ch_llr   = v;
        @(negedge clk);
        while (!ch_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ch_ready) chk("ch_timeout", 32'(waits), 32'(0));
        @(posedge clk); #1;
        ch_valid = 1'b0;
    endtask

    task automatic send_c2v(input logic [C2V_W-1:0] v, output int waits);
        waits     = 0;
        c2v_valid = 1'b1;
        c2v_msg   = v;
        @(negedge clk);
        while (!c2v_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!c2v_ready) chk("c2v_timeout", 32'(waits), 32'(0));
        @(posedge clk); #1;
        c2v_valid = 1'b0;
    endtask

    task automatic collect_block(input logic [LLR_W-1:0] ch, input logic [C2V_W-1:0] c0,
                                 input logic [C2V_W-1:0] c1, input logic [C2V_W-1:0] c2);
        int w;
        set_model(ch, c0, c1, c2);
        send_ch(ch);
        send_c2v(c0, w); chk("c2v_latency", 32'(w), 32'(0));
        send_c2v(c1, w); chk("c2v_gapless", 32'(w), 32'(0));
        send_c2v(c2, w); chk("c2v_gapless", 32'(w), 32'(0));
        m_idx    = 0;
        m_hard   = m_hard_pend;
        m_active = 1'b1;
    endtask

    task automatic emit_block(input logic [LLR_W-1:0] l0, input logic [LLR_W-1:0] l1,
                              input logic [LLR_W-1:0] l2, input logic hard_lit,
                              input int stall_idx, input int stall_len,
                              output int cycles, output int idx1n);
        logic [LLR_W-1:0] lit [DV];
        int seen = 0;
        int stalled = 0;
        int budget = 0;
        lit[0] = l0; lit[1] = l1; lit[2] = l2;
        cycles = 0;
        idx1n  = 0;
        chk("hard_at_entry", 32'(hard_bit), 32'(hard_lit));
        while (seen < DV && budget < 50) begin
            budget++;
            if (v2c_valid && int'(v2c_idx) == stall_idx && stalled < stall_len) begin
                v2c_ready = 1'b0;
                stalled++;
            end else begin
                v2c_ready = 1'b1;
            end
            @(negedge clk);
            chk("ch_ready_busy", 32'(ch_ready), 32'(0));
            if (v2c_valid) begin
                cycles++;
                if (v2c_idx == 4'd1) idx1n++;
                chk("v2c_idx_lit", 32'(v2c_idx), 32'(seen));
                chk("v2c_msg_lit", 32'(v2c_msg), 32'(lit[seen]));
                if (v2c_ready) seen++;
            end
            @(posedge clk); #1;
        end
        v2c_ready = 1'b1;
        if (seen < DV) chk("emit_timeout", 32'(seen), 32'(DV));
        @(negedge clk);
        chk("ch_ready_after", 32'(ch_ready), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        m_active = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_v2c_valid", 32'(v2c_valid), 32'(0));
            chk("rst_v2c_msg", 32'(v2c_msg), 32'(0));
            chk("rst_ch_ready", 32'(ch_ready), 32'(0));
            chk("rst_c2v_ready", 32'(c2v_ready), 32'(0));
            if (i > 0) chk("rst_hard_bit", 32'(hard_bit), 32'(0));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ch_ready_post_rst", 32'(ch_ready), 32'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int n1;
        int w;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_ch_ready", 32'(ch_ready), 32'(1));
        chk("init_c2v_ready", 32'(c2v_ready), 32'(0));
        chk("init_v2c_valid", 32'(v2c_valid), 32'(0));
        chk("init_v2c_idx", 32'(v2c_idx), 32'(0));
        chk("init_v2c_msg", 32'(v2c_msg), 32'(0));
        chk("init_hard_bit", 32'(hard_bit), 32'(0));
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // nominal: total +10
        collect_block(6'b001010, 5'b00011, 5'b10101, 5'b00010);
        emit_block(6'b000111, 6'b001111, 6'b001000, 1'b0, -1, 0, cyc, n1);
        chk("nom_emit_cycles", 32'(cyc), 32'(3));

        // saturation: total -76, all outputs clamp to -31
        collect_block(6'b111111, 5'b11111, 5'b11111, 5'b11111);
        emit_block(6'b111111, 6'b111111, 6'b111111, 1'b1, -1, 0, cyc, n1);

        // negative zero everywhere; hard_bit holds 1 until EMIT entry
        collect_block(6'b100000, 5'b10000, 5'b10000, 5'b10000);
        emit_block(6'b000000, 6'b000000, 6'b000000, 1'b0, -1, 0, cyc, n1);

        // reset mid-EMIT after hard_bit has gone high
        collect_block(6'b111111, 5'b11111, 5'b11111, 5'b11111);
        v2c_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        do_reset(2);

        // backpressure at idx 1 for 3 cycles
        collect_block(6'b001010, 5'b00011, 5'b10101, 5'b00010);
        emit_block(6'b000111, 6'b001111, 6'b001000, 1'b0, 1, 3, cyc, n1);
        chk("stall_emit_cycles", 32'(cyc), 32'(6));
        chk("stall_idx1_cycles", 32'(n1), 32'(4));

        // reset mid-COLLECT with large partial inputs, then a clean nominal block
        send_ch(6'b011111);
        send_c2v(5'b01111, w);
        send_c2v(5'b01111, w);
        do_reset(1);
        collect_block(6'b001010, 5'b00011, 5'b10101, 5'b00010);
        emit_block(6'b000111, 6'b001111, 6'b001000, 1'b0, -1, 0, cyc, n1);
        chk("post_abort_cycles", 32'(cyc), 32'(3));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/variable_node_unit.md
# variable_node_unit

Serial variable node unit (VNU) for the LDPC min-sum decoder; sits on both sides of the CNU in the iteration loop. Takes one channel LLR and DV check-to-variable (C2V) messages from the CNU, one per cycle. Then emits DV variable-to-check (V2C) messages, each being the total LLR minus the corresponding C2V message, back toward the CNU. Also registers the bit's hard decision.

## Interface
- DV, 3, variable-node degree (number of C2V inputs and V2C outputs per block); legal range 2..15
- LLR_W, 6, width of channel LLR and V2C message, sign-magnitude (MSB sign)
- C2V_W, 5, width of C2V message from CNU, sign-magnitude (MSB sign)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- ch_valid  input  1  channel LLR present
- ch_llr  input  LLR_W  channel LLR, sign-magnitude
- ch_ready  output  1  high only in IDLE
- c2v_valid  input  1  C2V message present
- c2v_msg  input  C2V_W  C2V message, sign-magnitude
- c2v_ready  output  1  high only in COLLECT
- v2c_valid  output  1  V2C message present, high only in EMIT
- v2c_msg  output  LLR_W  V2C message, sign-magnitude
- v2c_ready  input  1  downstream accepts V2C message
- v2c_idx  output  4  index (0..DV-1) of the message on v2c_msg
- hard_bit  output  1  hard decision of last completed block (1 = total < 0)

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. The valid side holds its data stable until the transfer.
- Internal arithmetic is two's complement, width LLR_W+4 (acc).
- Sign-magnitude conversion: sign=1 with magnitude 0 (negative zero) converts to 0.
- State IDLE:
  - ch_ready=1.
  - On ch transfer: acc <= ch_llr (converted), cnt <= 0, go to COLLECT.
  - c2v_valid is ignored.
- State COLLECT:
  - c2v_ready=1.
  - On each transfer: mem[cnt] <= c2v_msg (converted), acc <= acc + converted msg, cnt <= cnt+1.
  - On the transfer with cnt==DV-1: go to EMIT, cnt <= 0, hard_bit <= sign of final acc (acc+msg).
  - ch_valid is ignored.
- State EMIT:
  - v2c_valid=1, v2c_idx=cnt.
  - v2c_msg = sat(acc - mem[cnt]), converted to sign-magnitude.
  - sat clamps to ±(2^(LLR_W-1)-1), i.e. ±31 at default.
  - A zero result is emitted as all-zeros.
  - On transfer: cnt <= cnt+1. On the transfer with cnt==DV-1: go to IDLE.
- Only one block is in flight. The next ch transfer can occur no earlier than the cycle after the last V2C transfer.
- hard_bit changes only on EMIT entry and holds through later blocks until the next EMIT entry.

## Timing
- Reset values: state IDLE, cnt 0, acc 0, mem all 0, hard_bit 0, v2c_valid 0, c2v_ready 0, v2c_idx 0, v2c_msg 0.
- ch_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset asserted in any state, including mid-COLLECT or mid-EMIT, aborts the block.
  - Partial data is discarded.
  - The next cycle after deassertion is IDLE with reset values.
- Latency:
  - ch transfer to first possible c2v transfer: 1 cycle.
  - Last c2v transfer to v2c_valid high: 1 cycle.
  - hard_bit is valid in the same cycle v2c_valid first rises.
- Minimum block time with no stalls: 1 + DV + DV cycles (7 at DV=3).
- v2c_msg and v2c_idx are stable while v2c_valid=1 and v2c_ready=0.
- Gaps in c2v_valid or v2c_ready stall cnt with no loss.

## Test plan
- Reset: assert rst 2 cycles mid-EMIT, then release.
  - Required: v2c_valid=0, hard_bit=0, v2c_msg=000000 during reset.
  - Required: ch_ready=1 on the first cycle after release.
- Nominal, DV=3: ch_llr=001010 (+10); c2v=00011 (+3), 10101 (-5), 00010 (+2).
  - Required: total +10.
  - Required: v2c = 000111, 001111, 001000 at idx 0,1,2; hard_bit=0.
- Saturation: ch_llr=111111 (-31); c2v=11111 three times.
  - Required: total -76.
  - Required: every v2c = 111111 (clamped -31); hard_bit=1.
- Negative zero: ch_llr=100000; c2v=10000 three times.
  - Required: every v2c = 000000; hard_bit=0.
- Backpressure: nominal block with v2c_ready low for 3 cycles at idx 1.
  - Required: v2c_msg=001111 and v2c_idx=1 held for all 3 cycles.
  - Required: idx 2 follows one cycle after ready returns.
  - Required: ch_ready=0 until the last V2C transfer.
- Reset mid-COLLECT: apply rst after 2 c2v transfers, then run the nominal block.
  - Required: outputs match the nominal scenario exactly, with no residue from the aborted block.
